// File: rtl/sm3_pkg.sv
// Shared constants and state type for the SM3 streaming padder.
// The compression side owns V; SM3_IV is published here so both sides agree on it.
package sm3_pkg;

   localparam int BLOCK_BITS  = 512;
   localparam int BLOCK_BYTES = BLOCK_BITS / 8;
   localparam int LEN_BITS    = 64;
   localparam int LEN_OFFSET  = BLOCK_BYTES - LEN_BITS / 8;   // first byte of the length field

   localparam logic [7:0]   PAD_BYTE = 8'h80;
   localparam logic [255:0] SM3_IV   =
      256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

   typedef enum logic [1:0] {
      FILL,
      PAD,
      SEND,
      EXTRA
   } pad_state_t;

endpackage

// File: rtl/sm3_pad_mask.sv
// Byte-position decoder for padding: which bytes are already message data (index < bc)
// and where the 0x80 marker lands (index == bc; none when the block is full).
module sm3_pad_mask
   import sm3_pkg::*;
(
   input  logic [6:0]             bc,
   output logic [BLOCK_BYTES-1:0] keep_mask,
   output logic [BLOCK_BYTES-1:0] pad_onehot
);

   always_comb begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         keep_mask[i]  = (7'(i) < bc);
         pad_onehot[i] = (7'(i) == bc);
      end
   end

endmodule

// File: rtl/sm3_stream_padder.sv
// Streaming SM3 padder: packs IN_BYTES-wide beats into 512-bit blocks and appends the
// 0x80 marker, zero fill and 64-bit big-endian bit length, adding an extra block when needed.
module sm3_stream_padder
   import sm3_pkg::*;
#(
   parameter int IN_BYTES = 4,
   parameter int KEEP_W   = $clog2(IN_BYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_BYTES*8-1:0] in_data,
   input  logic                  in_last,
   input  logic [KEEP_W-1:0]     in_keep,
   output logic                  blk_valid,
   input  logic                  blk_ready,
   output logic [BLOCK_BITS-1:0] blk_data,
   output logic                  blk_last
);

   localparam int BEAT_BITS = IN_BYTES * 8;
   localparam int REST_BITS = BLOCK_BITS - BEAT_BITS;

   pad_state_t             state, state_nx;
   logic [6:0]             bc, beat_bytes, bc_sum;
   logic [LEN_BITS-1:0]    len;
   logic                   mark_done, to_extra;
   logic                   beat_fire, blk_fire, block_full, len_fits;
   logic [BLOCK_BYTES-1:0] keep_mask, pad_onehot;
   logic [BLOCK_BITS-1:0]  wr_mask, fill_data, pad_data;

   assign in_ready  = (state == FILL);
   assign blk_valid = (state == SEND);
   assign beat_fire = in_valid & in_ready;
   assign blk_fire  = blk_valid & blk_ready;

   always_comb begin
      beat_bytes = 7'(IN_BYTES);
      if (in_last && (in_keep < KEEP_W'(IN_BYTES)))
         beat_bytes = 7'(in_keep);
   end

   assign bc_sum     = bc + beat_bytes;
   assign block_full = (bc_sum == 7'(BLOCK_BYTES));
   assign len_fits   = (bc < 7'(LEN_OFFSET));

   // The whole beat is written; bytes past in_keep are later overwritten by the pad step.
   always_comb begin
      wr_mask   = {{BEAT_BITS{1'b1}}, {REST_BITS{1'b0}}} >> {bc, 3'b000};
      fill_data = (blk_data & ~wr_mask) | ({in_data, {REST_BITS{1'b0}}} >> {bc, 3'b000});
   end

   sm3_pad_mask u_pad_mask (
      .bc         (bc),
      .keep_mask  (keep_mask),
      .pad_onehot (pad_onehot)
   );

   // In EXTRA bc is 0, so the same decode yields the marker at byte 0 and no kept data.
   always_comb begin
      pad_data = '0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         if (keep_mask[i])
            pad_data[BLOCK_BITS-1-8*i -: 8] = blk_data[BLOCK_BITS-1-8*i -: 8];
         else if (pad_onehot[i] && !((state == EXTRA) && mark_done))
            pad_data[BLOCK_BITS-1-8*i -: 8] = PAD_BYTE;
      end
      if (len_fits)
         pad_data[LEN_BITS-1:0] = len;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nx;
   end

   always_comb begin
      // NOTE: state_nx gets its default before the case so no path can infer a latch.
      state_nx = state;
      case (state)
         FILL: begin
            if (beat_fire) begin
               if (in_last)         state_nx = PAD;
               else if (block_full) state_nx = SEND;
            end
         end
         PAD:     state_nx = SEND;
         SEND:    if (blk_fire) state_nx = to_extra ? EXTRA : FILL;
         EXTRA:   state_nx = SEND;
         default: state_nx = FILL;
      endcase
   end

   // NOTE: blk_data doubles as the fill buffer and is reset because its value is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bc        <= '0;
         len       <= '0;
         blk_data  <= '0;
         blk_last  <= 1'b0;
         mark_done <= 1'b0;
         to_extra  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register here samples pre-edge values.
         case (state)
            FILL: begin
               if (beat_fire) begin
                  blk_data <= fill_data;
                  bc       <= bc_sum;
                  len      <= len + (LEN_BITS'(beat_bytes) << 3);
                  blk_last <= 1'b0;
                  to_extra <= 1'b0;
               end
            end
            PAD: begin
               blk_data  <= pad_data;
               blk_last  <= len_fits;
               to_extra  <= !len_fits;
               mark_done <= (bc != 7'(BLOCK_BYTES));
            end
            SEND: begin
               if (blk_fire) begin
                  bc <= '0;
                  if (blk_last) len <= '0;
               end
            end
            EXTRA: begin
               blk_data <= pad_data;
               blk_last <= 1'b1;
               to_extra <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sm3_stream_padder.sv
// Randomised bench for sm3_stream_padder: a byte-queue padding model predicts every block,
// plus directed checks for latency, back-pressure and mid-message reset.
module tb_sm3_stream_padder;

   localparam int IN_BYTES = 4;
   localparam int KEEP_W   = 3;
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'd0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {8'h80, 504'd0};

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [511:0] data;
      logic         last;
   } blk_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [IN_BYTES*8-1:0] in_data = '0;
   logic                  in_last = 1'b0;
   logic [KEEP_W-1:0]     in_keep = '0;
   logic                  blk_valid;
   logic                  blk_ready = 1'b0;
   logic [511:0]          blk_data;
   logic                  blk_last;

   int   n_vec = 0, n_err = 0, cyc = 0, ready_mode = 0, last_accept = 0;
   blk_t exp_q[$];
   int   rise_q[$], hs_q[$], beat_cyc[$];
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sm3_stream_padder #(.IN_BYTES(IN_BYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_keep   (in_keep),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Padding straight from the standard: msg || 0x80 || zeros to 56 mod 64 || bitlen(64, BE).
   function automatic void model(input byte_q_t msg);
      byte_q_t     p;
      logic [63:0] bitlen;
      blk_t        b;
      int          nblk;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bitlen = 64'(msg.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
      nblk = p.size() / 64;
      for (int bi = 0; bi < nblk; bi++) begin
         b.data = '0;
         for (int i = 0; i < 64; i++) b.data[511-8*i -: 8] = p[bi*64+i];
         b.last = (bi == nblk - 1);
         exp_q.push_back(b);
      end
   endfunction

   function automatic byte_q_t rand_msg(input int n);
      byte_q_t m;
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      return m;
   endfunction

   // Entered and left on a falling edge. empty_tail adds a keep=0 last beat; stop_after aborts.
   task automatic drive_msg(input byte_q_t msg, input bit empty_tail, input int stop_after);
      int n, nb, g, idx;
      n  = msg.size();
      nb = empty_tail ? n / IN_BYTES + 1 : ((n == 0) ? 1 : (n + IN_BYTES - 1) / IN_BYTES);
      for (int b = 0; b < nb; b++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         in_valid = 1'b1;
         in_last  = (b == nb - 1);
         in_keep  = in_last ? KEEP_W'(n - b*IN_BYTES) : KEEP_W'($urandom_range(0, IN_BYTES));
         for (int j = 0; j < IN_BYTES; j++) begin
            idx = b*IN_BYTES + j;
            in_data[IN_BYTES*8-1-8*j -: 8] = (idx < n) ? msg[idx] : 8'($urandom);
         end
         g = 0;
         while (!in_ready) begin
            @(negedge clk);
            g++;
            if (g > 1000) begin
               check("in_ready_timeout", in_ready, 1);
               in_valid = 1'b0;
               return;
            end
         end
         last_accept = cyc;
         beat_cyc.push_back(cyc);
         @(negedge clk);
         in_valid = 1'b0;
         if (stop_after >= 0 && (b + 1)*IN_BYTES >= stop_after) return;
      end
   endtask

   task automatic wait_valid();
      int g = 0;
      while (!blk_valid && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("wait_valid", blk_valid, 1);
   endtask

   task automatic wait_drain(input int bound);
      int g = 0;
      while (exp_q.size() != 0 && g < bound) begin
         @(negedge clk);
         g++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rstp_blk_valid", blk_valid, 0);
      check("rstp_blk_data", blk_data, 0);
      check("rstp_blk_last", blk_last, 0);
      check("rstp_in_ready", in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_abc();
      byte_q_t msg;
      int      start;
      ready_mode = 1;
      msg = {8'h61, 8'h62, 8'h63};
      model(msg);
      drive_msg(msg, 1'b0, -1);
      start = last_accept;
      wait_valid();
      check("abc_latency", cyc - start, 2);
      check("abc_block", blk_data, ABC_BLK);
      check("abc_last", blk_last, 1);
      wait_drain(100);
   endtask

   // Block sink: drives blk_ready each falling edge and scores every valid cycle.
   initial begin
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       blk_ready = 1'($urandom_range(0, 1));
            1:       blk_ready = 1'b1;
            default: blk_ready = 1'b0;
         endcase
         if (rst_n && blk_valid) begin
            if (!prev_valid) rise_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_blk", blk_valid, 0);
            end else begin
               check("blk_data", blk_data, exp_q[0].data);
               check("blk_last", blk_last, exp_q[0].last);
               if (blk_ready) begin
                  hs_q.push_back(cyc);
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_valid = blk_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t msg;
      bit      et;
      int      n;

      repeat (3) @(negedge clk);
      check("rst_blk_valid", blk_valid, 0);
      check("rst_blk_last", blk_last, 0);
      check("rst_blk_data", blk_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      run_abc();

      ready_mode = 1;
      msg = {};
      model(msg);
      drive_msg(msg, 1'b0, -1);
      wait_valid();
      check("empty_block", blk_data, EMPTY_BLK);
      check("empty_last", blk_last, 1);
      wait_drain(100);

      // 56 bytes: marker fits, length does not; stall the first block for 10 cycles.
      ready_mode = 2;
      msg = rand_msg(56);
      model(msg);
      drive_msg(msg, 1'b0, -1);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         check("stall_in_ready", in_ready, 0);
         check("stall_valid", blk_valid, 1);
         @(negedge clk);
      end
      ready_mode = 1;
      wait_drain(100);

      // "abcd" x16: full data block, then an extra block carrying 0x80 and the length.
      rise_q.delete();
      hs_q.delete();
      msg = {};
      for (int i = 0; i < 64; i++) msg.push_back(8'h61 + 8'(i % 4));
      model(msg);
      drive_msg(msg, 1'b0, -1);
      wait_drain(100);
      if (rise_q.size() >= 2 && hs_q.size() >= 1)
         check("extra_latency", rise_q[1] - hs_q[0], 2);
      else
         check("extra_rises", rise_q.size(), 2);

      // 64 bytes then an empty last beat: the full block must appear one cycle after its beat.
      rise_q.delete();
      beat_cyc.delete();
      msg = rand_msg(64);
      model(msg);
      drive_msg(msg, 1'b1, -1);
      wait_drain(100);
      if (rise_q.size() >= 1 && beat_cyc.size() >= 16)
         check("fill_latency", rise_q[0] - beat_cyc[15], 1);
      else
         check("fill_rises", rise_q.size(), 2);

      // Reset mid-message after 20 bytes, then a clean "abc".
      msg = rand_msg(40);
      drive_msg(msg, 1'b0, 20);
      pulse_reset();
      run_abc();

      // Reset while a full block is held by back-pressure.
      ready_mode = 2;
      msg = rand_msg(64);
      model(msg);
      drive_msg(msg, 1'b1, 64);
      wait_valid();
      pulse_reset();
      run_abc();

      for (int m = 0; m < 40; m++) begin
         ready_mode = 0;
         n   = $urandom_range(0, 150);
         et  = (n % IN_BYTES == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         msg = rand_msg(n);
         model(msg);
         drive_msg(msg, et, -1);
      end
      wait_drain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
